// File: rtl/oled_pkg.sv
// Shared constants for the SSD1306 bin-display sequencer:
// state encoding, command tables and the column renderer.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_INIT,
        ST_IDLE,
        ST_WIN,
        ST_DATA,
        ST_ERR
    } seq_state_e;

    localparam int INIT_LEN = 25;

    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;

    localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F,
        8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA,
        8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    // Column range 0..127, page range 0..0
    localparam logic [7:0] WIN_CMDS [6] = '{
        8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h00
    };

    // 16 columns per bit, MSB leftmost; last two columns are a gap
    function automatic logic [7:0] col_byte(
        input logic [7:0] val,
        input logic [6:0] col
    );
        logic [2:0] b;
        b = 3'd7 - col[6:4];
        if (col[3:0] >= 4'd14)
            return 8'h00;
        return val[b] ? 8'hFF : 8'h81;
    endfunction

endpackage

// File: rtl/oled_bin_seq_if.sv
// Byte-level handshake between the sequencer and the I2C master.
// One byte outstanding at a time; ACK status returns as a pulse.
interface oled_bin_seq_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_stop;
    logic       tx_ready;
    logic       tx_ack_valid;
    logic       tx_nack;

    modport master (
        output tx_valid, tx_data, tx_start, tx_stop,
        input  tx_ready, tx_ack_valid, tx_nack
    );

    modport slave (
        input  tx_valid, tx_data, tx_start, tx_stop,
        output tx_ready, tx_ack_valid, tx_nack
    );
endinterface

// File: rtl/oled_bin_seq.sv
// SSD1306 sequencer: boot delay, init list, page-0 binary redraw.
// Optional OLED_SEQ_COALESCE_EN keeps the last update seen while busy.
import oled_pkg::*;

module oled_bin_seq #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int STARTUP_US = 100
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           update,
    input  logic [7:0]     value,
    oled_bin_seq_if.master tx,
    output logic           init_done,
    output logic           busy,
    output logic           err
);

    localparam int STARTUP_CYCLES = CLK_HZ / 1_000_000 * STARTUP_US;

    localparam logic [2:0] S_BOOT = ST_BOOT;
    localparam logic [2:0] S_INIT = ST_INIT;
    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_WIN  = ST_WIN;
    localparam logic [2:0] S_DATA = ST_DATA;
    localparam logic [2:0] S_ERR  = ST_ERR;

    logic [2:0]  state;
    logic        wait_ack;
    logic [7:0]  idx;
    logic [7:0]  val_q;
    logic [31:0] boot_cnt;

    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic        tx_stop_q;

    logic        go_win;
    logic [7:0]  go_val;
    logic [7:0]  nidx;
    logic [7:0]  last;

    function automatic logic [7:0] last_idx(input logic [2:0] st);
        case (st)
            S_INIT:  return 8'(INIT_LEN);
            S_WIN:   return 8'd6;
            default: return 8'd128;
        endcase
    endfunction

    function automatic logic [7:0] byte_at(
        input logic [2:0] st,
        input logic [7:0] i,
        input logic [7:0] v
    );
        logic [7:0] b;
        b = 8'h00;
        case (st)
            S_INIT: begin
                if (i == 8'd0) b = CTRL_CMD;
                else           b = INIT_CMDS[5'(i - 8'd1)];
            end
            S_WIN: begin
                if (i == 8'd0) b = CTRL_CMD;
                else           b = WIN_CMDS[3'(i - 8'd1)];
            end
            S_DATA: begin
                if (i == 8'd0) b = CTRL_DATA;
                else           b = col_byte(v, 7'(i - 8'd1));
            end
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign nidx = idx + 8'd1;
    assign last = last_idx(state);

`ifdef OLED_SEQ_COALESCE_EN
    logic       pend;
    logic [7:0] pend_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= 1'b0;
            pend_val <= 8'h00;
        end else if (state == S_ERR) begin
            pend <= 1'b0;
        end else if (state == S_IDLE) begin
            pend <= 1'b0;
        end else if (update) begin
            pend     <= 1'b1;
            pend_val <= value;
        end
    end

    always_comb begin
        go_win = 1'b0;
        go_val = value;
        if (state == S_IDLE) begin
            if (update) begin
                go_win = 1'b1;
            end else if (pend) begin
                go_win = 1'b1;
                go_val = pend_val;
            end
        end
    end
`else
    always_comb begin
        go_win = (state == S_IDLE) && update;
        go_val = value;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_BOOT;
            wait_ack   <= 1'b0;
            idx        <= 8'd0;
            val_q      <= 8'h00;
            boot_cnt   <= 32'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            tx_stop_q  <= 1'b0;
            init_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    if (boot_cnt == 32'(STARTUP_CYCLES - 1)) begin
                        state    <= S_INIT;
                        idx      <= 8'd0;
                        wait_ack <= 1'b0;
                    end else begin
                        boot_cnt <= boot_cnt + 32'd1;
                    end
                end
                S_IDLE: begin
                    if (go_win) begin
                        state      <= S_WIN;
                        val_q      <= go_val;
                        idx        <= 8'd0;
                        wait_ack   <= 1'b0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= CTRL_CMD;
                        tx_start_q <= 1'b1;
                        tx_stop_q  <= 1'b0;
                    end
                end
                S_INIT, S_WIN, S_DATA: begin
                    if (!wait_ack) begin
                        // First byte after boot is loaded here;
                        // later bytes are loaded on the ACK.
                        if (!tx_valid_q) begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= byte_at(state, idx, val_q);
                            tx_start_q <= (idx == 8'd0);
                            tx_stop_q  <= (idx == last);
                        end else if (tx.tx_ready) begin
                            tx_valid_q <= 1'b0;
                            wait_ack   <= 1'b1;
                        end
                    end else if (tx.tx_ack_valid) begin
                        wait_ack <= 1'b0;
                        if (tx.tx_nack) begin
                            state     <= S_ERR;
                            err       <= 1'b1;
                            init_done <= 1'b0;
                        end else if (idx == last) begin
                            if (state == S_INIT) begin
                                state     <= S_IDLE;
                                init_done <= 1'b1;
                            end else if (state == S_WIN) begin
                                state      <= S_DATA;
                                idx        <= 8'd0;
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= CTRL_DATA;
                                tx_start_q <= 1'b1;
                                tx_stop_q  <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            idx        <= nidx;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= byte_at(state, nidx, val_q);
                            tx_start_q <= 1'b0;
                            tx_stop_q  <= (nidx == last);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != S_IDLE) && (state != S_ERR);
    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_start = tx_start_q;
    assign tx.tx_stop  = tx_stop_q;

endmodule

// File: tb/tb_oled_bin_seq.sv
// Directed bench for oled_bin_seq: boot timing, init list,
// redraw contents, back-pressure, reset mid-WIN and NACK handling.
module tb_oled_bin_seq;

    localparam int SC = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       update = 1'b0;
    logic [7:0] value = 8'h00;
    logic       init_done;
    logic       busy;
    logic       err;

    oled_bin_seq_if bus();

    oled_bin_seq #(
        .CLK_HZ    (1_000_000),
        .STARTUP_US(SC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .update   (update),
        .value    (value),
        .tx       (bus),
        .init_done(init_done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    int         stall_at = -1;
    int         inj_at   = -1;
    int         inj2_at  = -1;
    logic [7:0] inj_val  = 8'h00;
    logic [7:0] inj2_val = 8'h00;
    logic [7:0] cols [128];

    logic [7:0] init_exp [26] = '{
        8'h00,
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F,
        8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA,
        8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    logic [7:0] win_exp [7] = '{
        8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h00
    };

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] col_exp(input logic [7:0] v,
                                           input int c);
        int seg;
        seg = c / 16;
        if ((c % 16) > 13)
            return 8'h00;
        if (v[7 - seg])
            return 8'hFF;
        return 8'h81;
    endfunction

    function automatic logic [9:0] flags(input logic s, input logic p,
                                         input logic [7:0] d);
        return {s, p, d};
    endfunction

    // Play the master for one byte: optional ready stall, then ACK/NACK
    task automatic xfer(input int hold, input bit nack,
                        output logic [9:0] got);
        int t;
        t = 0;
        got = '1;
        while (!bus.tx_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.tx_valid) begin
            chk("valid_timeout", 32'd0, 32'd1);
            return;
        end
        got = flags(bus.tx_start, bus.tx_stop, bus.tx_data);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_stable",
                {bus.tx_valid, bus.tx_start, bus.tx_stop, bus.tx_data},
                {1'b1, got});
        end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        chk("valid_drop", bus.tx_valid, 1'b0);
        @(negedge clk);
        bus.tx_ack_valid = 1'b1;
        bus.tx_nack      = nack;
        @(negedge clk);
        bus.tx_ack_valid = 1'b0;
        bus.tx_nack      = 1'b0;
    endtask

    task automatic boot_chk();
        @(negedge clk);
        rst = 1'b0;
        repeat (SC) @(negedge clk);
        chk("boot_quiet", bus.tx_valid, 1'b0);
        @(negedge clk);
        chk("boot_first", {bus.tx_valid, bus.tx_start, bus.tx_data},
            {1'b1, 1'b1, 8'h00});
    endtask

    task automatic do_init(input int nack_at);
        logic [9:0] g;
        for (int i = 0; i < 26; i++) begin
            xfer(0, i == nack_at, g);
            chk($sformatf("init[%0d]", i), g,
                flags(i == 0, i == 25, init_exp[i]));
            if (i == nack_at)
                return;
        end
    endtask

    task automatic pulse_update(input logic [7:0] v);
        update = 1'b1;
        value  = v;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic redraw(input logic [7:0] v);
        logic [9:0] g;
        for (int i = 0; i < 7; i++) begin
            xfer(0, 1'b0, g);
            chk($sformatf("win[%0d]", i), g,
                flags(i == 0, i == 6, win_exp[i]));
        end
        for (int i = 0; i < 129; i++) begin
            if (i == inj_at)  pulse_update(inj_val);
            if (i == inj2_at) pulse_update(inj2_val);
            xfer((i == stall_at) ? 5 : 0, 1'b0, g);
            if (i == 0) begin
                chk("data_ctrl", g, flags(1'b1, 1'b0, 8'h40));
            end else begin
                cols[i-1] = g[7:0];
                chk($sformatf("col[%0d]", i - 1), g,
                    flags(1'b0, i == 128, col_exp(v, i - 1)));
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] g;
        bit         seen;
        bus.tx_ready     = 1'b0;
        bus.tx_ack_valid = 1'b0;
        bus.tx_nack      = 1'b0;

        #12;
        chk("rst_tx", {bus.tx_valid, bus.tx_start, bus.tx_stop,
            bus.tx_data}, 11'd0);
        chk("rst_flags", {init_done, busy, err}, 3'b010);

        boot_chk();
        do_init(-1);
        chk("init_done", {init_done, busy, err}, 3'b100);
        chk("init_quiet", bus.tx_valid, 1'b0);

        @(negedge clk);
        pulse_update(8'hA5);
        chk("upd_busy", busy, 1'b1);
        chk("upd_valid", {bus.tx_valid, bus.tx_start, bus.tx_data},
            {1'b1, 1'b1, 8'h00});
        stall_at = 50;
`ifdef OLED_SEQ_COALESCE_EN
        inj_at   = 60;
        inj_val  = 8'h01;
        inj2_at  = 70;
        inj2_val = 8'h80;
`else
        inj_at  = 60;
        inj_val = 8'h3C;
`endif
        redraw(8'hA5);
        stall_at = -1;
        inj_at   = -1;
        inj2_at  = -1;
        chk("c0",   cols[0],   8'hFF);
        chk("c13",  cols[13],  8'hFF);
        chk("c14",  cols[14],  8'h00);
        chk("c15",  cols[15],  8'h00);
        chk("c16",  cols[16],  8'h81);
        chk("c29",  cols[29],  8'h81);
        chk("c112", cols[112], 8'hFF);
        chk("c125", cols[125], 8'hFF);
        chk("c127", cols[127], 8'h00);
`ifdef OLED_SEQ_COALESCE_EN
        redraw(8'h80);
`endif
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.tx_valid) seen = 1'b1;
        end
        chk("drop_quiet", {seen, busy}, 2'b00);

        pulse_update(8'h0F);
        for (int i = 0; i < 3; i++) begin
            xfer(0, 1'b0, g);
            chk($sformatf("win2[%0d]", i), g,
                flags(i == 0, 1'b0, win_exp[i]));
        end
        rst = 1'b1;
        #1;
        chk("midrst_tx", {bus.tx_valid, bus.tx_start, bus.tx_stop,
            bus.tx_data}, 11'd0);
        chk("midrst_flags", {init_done, busy, err}, 3'b010);
        boot_chk();
        do_init(-1);
        chk("reinit_done", {init_done, busy, err}, 3'b100);

        @(negedge clk);
        rst = 1'b1;
        boot_chk();
        do_init(3);
        chk("nack_flags", {init_done, busy, err}, 3'b001);
        @(negedge clk);
        pulse_update(8'h55);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tx_valid) seen = 1'b1;
        end
        chk("nack_quiet", {seen, err, init_done}, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/oled_bin_seq.md
# oled_bin_seq

Sequencer between the bin-counter logic and the byte-level I2C master that drives the SSD1306 OLED. After reset it waits a power-up delay, then streams the fixed SSD1306 init command list. After that, on each `update` pulse, it redraws page 0 as an 8-segment binary rendering of `value[7:0]`. It owns the master's byte handshake, frames every transaction with start/stop flags, and latches any NACK into a sticky error suitable for a board LED.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: system clock frequency.
- `STARTUP_US`, 100: delay after reset before the first transaction; `STARTUP_CYCLES = CLK_HZ/1_000_000*STARTUP_US`.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `update`  in  1: one-cycle request to redraw the display.
- `value`  in  8: count to display; sampled with `update`.
- `tx_valid`  out  1: byte offered to the I2C master.
- `tx_data`  out  8: byte payload.
- `tx_start`  out  1: byte is the first of a transaction. The master emits START plus the SSD1306 write address before it.
- `tx_stop`  out  1: byte is the last of a transaction. The master emits STOP after it.
- `tx_ready`  in  1: master accepts the byte when `tx_valid & tx_ready`.
- `tx_ack_valid`  in  1: one-cycle pulse when the accepted byte's ACK slot completes.
- `tx_nack`  in  1: qualifies `tx_ack_valid`; 1 means NACK.
- `init_done`  out  1: init list completed successfully.
- `busy`  out  1: a transaction or the startup delay is in progress.
- `err`  out  1: sticky NACK flag.

## Operation
- States: BOOT, INIT, IDLE, WIN, DATA, ERR. Each non-idle byte phase alternates between SEND and WAIT_ACK.
- BOOT: the counter runs to `STARTUP_CYCLES-1`, then the block enters INIT.
- INIT is one transaction of 26 bytes:
  - control byte 0x00 (`tx_start=1`), then 25 commands: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
  - The last byte carries `tx_stop=1`.
  - On success the block enters IDLE with `init_done=1`.
- IDLE: `update` is accepted and `value` is latched into `val_q`; the block enters WIN.
- WIN is one transaction of 7 bytes: 00 21 00 7F 22 00 00. It sets the column range 0–127 and page 0.
- DATA is one transaction of 129 bytes: 0x40, then 128 column bytes.
  - Column c maps to bit b = 7 − c/16, so the MSB is leftmost.
  - For c%16 < 14: byte = 0xFF if `val_q[b]`, else 0x81.
  - For c%16 ≥ 14: byte = 0x00.
  - After the last byte the block returns to IDLE.
- Byte protocol:
  - SEND holds `tx_valid`, `tx_data` and the flags stable until `tx_ready`.
  - WAIT_ACK waits for `tx_ack_valid`. Only one byte is ever outstanding.
- NACK in any state: the block enters ERR, sets `err=1` and clears `init_done`, and issues no further bytes. The master is responsible for releasing the bus. ERR is exited only by `rst`.
- `update` outside IDLE is dropped (unless `OLED_SEQ_COALESCE_EN` is defined).
- Reset mid-transaction: all outputs return to reset values immediately and the block goes to BOOT. It never completes a partial stop.

## Timing
- Reset values: `tx_valid=0`, `tx_data=0`, `tx_start=0`, `tx_stop=0`, `init_done=0`, `busy=1`, `err=0`. State is BOOT with counters 0.
- Startup delay:
  - `tx_valid` first rises exactly `STARTUP_CYCLES+1` cycles after `rst` deasserts.
  - `busy=0` only in IDLE and ERR.
- Byte issue:
  - `tx_valid` rises the cycle after entering SEND.
  - It falls the cycle after the `tx_valid & tx_ready` handshake.
- Next byte:
  - The next `tx_valid` rises the cycle after `tx_ack_valid` with ACK.
  - `tx_ack_valid` arriving in the same cycle as the handshake is ignored; the master guarantees at least one cycle of separation.
- Update latency: `update` in IDLE at cycle t gives `busy=1` at t+1 and `tx_valid` (0x00, start) at t+1.
- `val_q` is stable for the whole redraw.

## Configuration
- Macro: `OLED_SEQ_COALESCE_EN`.
- Defined:
  - `update` while not in IDLE sets a pending flag and overwrites the pending value; last write wins.
  - On return to IDLE with pending set, the block enters WIN the next cycle with the pending value and clears pending.
  - Pending is cleared on ERR entry.
- Undefined: `update` outside IDLE is ignored and no pending register exists.

## Structure
- Package `oled_pkg`:
  - state enum `seq_state_e`;
  - `INIT_LEN=25` and the init command array `INIT_CMDS`;
  - `CTRL_CMD=8'h00`, `CTRL_DATA=8'h40`;
  - `WIN_CMDS` (6 bytes);
  - function `col_byte(val, col)` implementing the column mapping.
- No sub-module; the byte-index counter (8 bits, 0..128) and the boot counter live in `oled_bin_seq`.

## Test plan
- Reset, then master always ready and ACK:
  - first byte 0x00 with start at cycle `STARTUP_CYCLES+1`;
  - 26 bytes in total, with 0xAF carrying stop;
  - `init_done=1`, `busy=0`.
- `update` with value 0xA5 after init:
  - WIN bytes 00 21 00 7F 22 00 00;
  - DATA starts with 0x40;
  - columns 0–13 are 0xFF, 16–29 are 0x81, 14–15 are 0x00;
  - columns 112–125 are 0xFF.
- Master `tx_ready` low for 5 cycles mid-DATA: byte and flags are held stable, with no duplicate or skipped byte.
- NACK on init byte 3: `err=1`, `init_done=0`, no further `tx_valid`; a later `update` is ignored.
- `update` during DATA: the value is dropped. With `OLED_SEQ_COALESCE_EN`, two updates (0x01 then 0x80) produce exactly one redraw showing 0x80.
- `rst` asserted mid-WIN: outputs take reset values in the same cycle; after release, the full init is repeated.
